lookup_arbiter: RTL
===================

Name: lookup_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered 3-input lookup unit (inputs a/b/c, outputs y/z, updated on posedge clk) among NREQ requesters.
- Accepts a 3-bit code from each requester and grants one requester at a time.
- Drives the code onto the lookup unit, waits out its latency, captures y/z, and returns a tagged response.
- Sits between the requesting blocks and the lookup datapath; owns all lookup-unit inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 1, lookup-unit latency in clocks from input change to valid y/z (1..4).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- code  input  3*NREQ  per-requester code; bits [3i+2:3i] belong to requester i, ordered {a,b,c} MSB..LSB.
- gnt  output  NREQ  one-hot grant pulse, one cycle.
- lk_a, lk_b, lk_c  output  1 each  drive the lookup unit inputs.
- lk_y, lk_z  input  1 each  lookup unit outputs.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  clog2(NREQ)  index of the requester being answered.
- rsp_y  output  1  captured y.
- rsp_z  output  1  captured z; forced 0 when rsp_zdef=0.
- rsp_zdef  output  1  1 only for codes 3'b111, 3'b110, 3'b100 (z defined).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at posedge), all registers cleared:
  - gnt=0, lk_a/b/c=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_z=0, rsp_zdef=0, busy=0.
  - state=IDLE, priority pointer=0 (requester 0 highest), wait counter=0.
- rst mid-transaction aborts it: no gnt or rsp_valid is emitted for the aborted request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0 at the edge, select the first asserted requester starting at the pointer and wrapping NREQ-1 -> 0.
  - Latch its code and index; register gnt one-hot and lk_a/b/c = latched code; go to ISSUE.
  - If req == 0, stay in IDLE; gnt=0.
- ISSUE (one cycle): gnt high for this cycle only; load wait counter with LAT-1; go to WAIT.
- WAIT: decrement the counter each cycle; at 0, capture lk_y and lk_z and go to RESP.
  - With LAT=1, WAIT lasts exactly one cycle.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id, rsp_y, rsp_zdef.
  - rsp_z = captured lk_z when rsp_zdef=1, else 0.
  - Pointer <- (granted index + 1) mod NREQ; go to IDLE.
- lk_a/b/c hold the granted code from ISSUE through RESP and keep their last value in IDLE. They change only on a new grant.
- Timing: req sampled at edge T -> gnt in cycle T+1 -> rsp_valid in cycle T+2+LAT.
  - Back-to-back grants are LAT+3 cycles apart.
- Requester protocol:
  - Hold req and a stable code until gnt is seen.
  - Dropping req before gnt withdraws the request with no side effect.
  - req still high in the cycle after gnt counts as a new request.
- Code and req changes after the grant edge do not affect the transaction in flight.
- rsp outputs other than rsp_valid hold their value until the next RESP.
- One transaction outstanding at a time; no queueing; busy masks nothing, it is informational only.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 for 10 cycles -> all outputs 0, busy=0, no gnt.
- Single request, LAT=1: req=4'b0001, code0=3'b110 -> gnt=0001 one cycle later; rsp_valid 3 cycles after sampling with rsp_id=0, rsp_y=1, rsp_z=1, rsp_zdef=1; lk_a/b/c=1,1,0 held until the next grant.
- Round-robin fairness: req=4'b1111 held, codes 111/110/100/011 -> grants 0,1,2,3,0 in order, 4 cycles apart. Responses are (y,z,zdef) = (0,1,1), (1,1,1), (0,0,1), (0,0,0).
- Pointer wrap and sparse requests: after granting 3, req=4'b0101 -> next grant 0, then 2.
- LAT=3 build: single request -> rsp_valid exactly 5 cycles after the req sample edge; 6 cycles between consecutive grants.
- Reset mid-operation: assert rst in the WAIT cycle -> no rsp_valid; the next request after reset is granted by priority from requester 0.

Source files
------------

// File: rtl/lookup_arbiter.sv
// lookup_arbiter: round-robin sharing of one registered 3-input lookup unit.
// Ports: clk/rst, req/code in, gnt out; lk_a/b/c out, lk_y/z in; rsp_* out, busy.
module lookup_arbiter #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 1,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] code,
  output logic [NREQ-1:0]   gnt,
  output logic              lk_a,
  output logic              lk_b,
  output logic              lk_c,
  input  logic              lk_y,
  input  logic              lk_z,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic              rsp_y,
  output logic              rsp_z,
  output logic              rsp_zdef,
  output logic              busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        code_q, code_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rv_q, rv_d;
  logic              ry_q, ry_d;
  logic              rz_q, rz_d;
  logic              rzd_q, rzd_d;
  logic [IW-1:0]     sel;

  // First asserted requester at or after the pointer, wrapping.
  function automatic logic [IW-1:0] pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   p
  );
    logic          found;
    logic [IW-1:0] s;
    int            k;
    found = 1'b0;
    s     = p;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(p) + i) % NREQ;
      if (!found && r[k]) begin
        found = 1'b1;
        s     = IW'(k);
      end
    end
    return s;
  endfunction

  function automatic logic zdef(input logic [2:0] c);
    return (c == 3'b111) || (c == 3'b110) || (c == 3'b100);
  endfunction

  assign sel = pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    gnt_d   = '0;
    rv_d    = 1'b0;
    ry_d    = ry_q;
    rz_d    = rz_q;
    rzd_d   = rzd_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          id_d    = sel;
          gnt_d   = NREQ'(1) << sel;
          code_d  = code[3*int'(sel) +: 3];
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rv_d    = 1'b1;
          ry_d    = lk_y;
          rzd_d   = zdef(code_q);
          rz_d    = lk_z & zdef(code_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (int'(id_q) == NREQ - 1) ptr_d = '0;
        else                        ptr_d = id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      gnt_q   <= '0;
      rv_q    <= 1'b0;
      ry_q    <= 1'b0;
      rz_q    <= 1'b0;
      rzd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      ry_q    <= ry_d;
      rz_q    <= rz_d;
      rzd_q   <= rzd_d;
    end
  end

  assign gnt       = gnt_q;
  assign lk_a      = code_q[2];
  assign lk_b      = code_q[1];
  assign lk_c      = code_q[0];
  assign rsp_valid = rv_q;
  assign rsp_id    = id_q;
  assign rsp_y     = ry_q;
  assign rsp_z     = rz_q;
  assign rsp_zdef  = rzd_q;
  assign busy      = (state_q != IDLE);

endmodule
